// File: rtl/dmem_copy.sv
// dmem_copy: block-copy engine driving both ports of the dual-port data memory.
//
// A copy is requested with start/src/dst/len while idle. The engine issues
// one read per clock from src upward, and one clock later writes each returned
// word to the matching address from dst upward. Address arithmetic wraps
// modulo 2^ADDR_W.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   start, src, dst, len copy request; operands latched when accepted in IDLE
//   abort                cancel an in-flight copy (no done pulse)
//   busy                 copy in progress
//   done                 one-cycle pulse after a normal completion
//   words_done           words written by the current / most recent copy
//   mem_raddr, mem_rdata memory read port (memory registers data on negedge)
//   mem_waddr, mem_wdata,
//   mem_wen              memory write port (memory writes on negedge)
module dmem_copy #(
    parameter int ADDR_W = 24,
    parameter int WORD_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_done,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wen
);

    localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] W_ZERO = {WORD_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] src_r, src_s;
    logic [ADDR_W-1:0] dst_r, dst_s;
    logic [ADDR_W-1:0] len_r, len_s;
    // cnt_r = number of words already captured from the read port
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0] cnt_inc_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [ADDR_W-1:0] words_done_r, words_done_s;
    logic [ADDR_W-1:0] raddr_r, raddr_s;
    logic [ADDR_W-1:0] waddr_r, waddr_s;
    logic [WORD_W-1:0] wdata_r, wdata_s;
    logic              wen_r, wen_s;

    // Next-state and next-output logic for the copy sequencer
    always_comb begin
        state_s      = state_r;
        src_s        = src_r;
        dst_s        = dst_r;
        len_s        = len_r;
        cnt_s        = cnt_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        raddr_s      = raddr_r;
        waddr_s      = waddr_r;
        wdata_s      = wdata_r;
        wen_s        = wen_r;
        cnt_inc_s    = cnt_r + A_ONE;

        // A write happened during the cycle just ending, so it is now counted.
        // This also covers the abort edge: the write before it did complete.
        if (wen_r) begin
            words_done_s = words_done_r + A_ONE;
        end else begin
            words_done_s = words_done_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len != A_ZERO) begin
                        src_s        = src;
                        dst_s        = dst;
                        len_s        = len;
                        cnt_s        = A_ZERO;
                        raddr_s      = src;
                        words_done_s = A_ZERO;
                        busy_s       = 1'b1;
                        state_s      = RUN;
                    end else begin
                        // Empty copy: complete immediately, never touch memory
                        words_done_s = A_ZERO;
                        done_s       = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    wen_s   = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    // Word cnt_r was read last cycle; write it now
                    waddr_s = dst_r + cnt_r;
                    wdata_s = mem_rdata;
                    wen_s   = 1'b1;
                    cnt_s   = cnt_inc_s;
                    if (cnt_inc_s < len_r) begin
                        raddr_s = src_r + cnt_inc_s;
                    end else begin
                        // Last word is being written this cycle
                        state_s = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    wen_s   = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    wen_s   = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                wen_s   = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            src_r        <= A_ZERO;
            dst_r        <= A_ZERO;
            len_r        <= A_ZERO;
            cnt_r        <= A_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            words_done_r <= A_ZERO;
            raddr_r      <= A_ZERO;
            waddr_r      <= A_ZERO;
            wdata_r      <= W_ZERO;
            wen_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            src_r        <= src_s;
            dst_r        <= dst_s;
            len_r        <= len_s;
            cnt_r        <= cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            words_done_r <= words_done_s;
            raddr_r      <= raddr_s;
            waddr_r      <= waddr_s;
            wdata_r      <= wdata_s;
            wen_r        <= wen_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign words_done = words_done_r;
    assign mem_raddr  = raddr_r;
    assign mem_waddr  = waddr_r;
    assign mem_wdata  = wdata_r;
    assign mem_wen    = wen_r;

endmodule

// File: tb/tb_dmem_copy.sv
// Testbench for dmem_copy: a 1024-word address-masked memory model, a
// copy-semantics reference model of expected memory contents, and one task
// per scenario.
module tb_dmem_copy;

    localparam int MW  = 10;
    localparam int MSZ = 1024;

    logic        clk, rst, start, abort;
    logic [23:0] src, dst, len;
    logic        busy, done, mem_wen;
    logic [23:0] words_done, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    logic [23:0] mem     [0:MSZ-1];
    logic [23:0] exp_mem [0:MSZ-1];
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];
    int          wen_count;
    int          checks;
    int          errors;

    dmem_copy #(.ADDR_W(24), .WORD_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .abort(abort), .busy(busy), .done(done), .words_done(words_done),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: read registered on negedge returns the pre-write value
    always @(negedge clk) begin
        mem_rdata <= mem[mem_raddr[MW-1:0]];
        if (mem_wen) begin
            mem[mem_waddr[MW-1:0]] <= mem_wdata;
            wr_q.push_back(mem_waddr);
            wen_count++;
        end
    end

    // Reference: destination word i receives the pre-copy source word i
    function automatic void model_copy(input logic [23:0] s, input logic [23:0] d, input int n);
        logic [23:0] snap [0:MSZ-1];
        logic [23:0] sa, da;
        snap = exp_mem;
        for (int i = 0; i < n; i++) begin
            sa = s + 24'(i);
            da = d + 24'(i);
            exp_mem[da[MW-1:0]] = snap[sa[MW-1:0]];
        end
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < MSZ; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    function automatic int seq_errs(input logic [23:0] q[$], input logic [23:0] base, input int n);
        int e = 0;
        if (q.size() != n) return n + 1;
        for (int i = 0; i < n; i++) if (q[i] !== base + 24'(i)) e++;
        return e;
    endfunction

    task automatic fill_mem();
        logic [31:0] v;
        for (int i = 0; i < MSZ; i++) begin
            v = $urandom;
            mem[i] <= v[23:0];
            exp_mem[i] = v[23:0];
        end
    endtask

    // Start a copy (called just after a posedge) and return in the done cycle
    task automatic run_copy(input logic [23:0] s, input logic [23:0] d, input logic [23:0] l,
                            output int busy_cycles, output int done_cycle);
        rd_q.delete();
        wr_q.delete();
        wen_count = 0;
        src = s; dst = d; len = l; start = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cycles = 0;
        done_cycle  = -1;
        for (int c = 0; c < int'(l) + 20; c++) begin
            if (c < int'(l)) rd_q.push_back(mem_raddr);
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cycle < 0) begin
            checks++; errors++;
            $display("FAIL run_copy_timeout: no done within budget for len %0d", l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, mem_wen} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, mem_wen});
        end
        checks++;
        if ({words_done, mem_raddr, mem_waddr, mem_wdata} !== 96'd0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {words_done, mem_raddr, mem_waddr, mem_wdata});
        end
        rst = 1'b0;
        wen_count = 0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (wen_count !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_quiet: wen_count %0d busy %b expected 0 0", wen_count, busy);
        end
    endtask

    task automatic test_basic();
        int bc, dc;
        for (int i = 0; i < 4; i++) begin
            mem[16+i] <= 24'hA00001 + 24'(i);
            exp_mem[16+i] = 24'hA00001 + 24'(i);
        end
        model_copy(24'h000010, 24'h000040, 4);
        run_copy(24'h000010, 24'h000040, 24'd4, bc, dc);
        checks++;
        if (dc !== 5 || bc !== 5) begin
            errors++; $display("FAIL basic_timing: done cycle %0d busy cycles %0d expected 5 5", dc, bc);
        end
        checks++;
        if (wen_count !== 4 || words_done !== 24'd4) begin
            errors++; $display("FAIL basic_count: wen %0d words_done %0d expected 4 4", wen_count, words_done);
        end
        checks++;
        if (seq_errs(rd_q, 24'h000010, 4) != 0 || seq_errs(wr_q, 24'h000040, 4) != 0) begin
            errors++; $display("FAIL basic_addr: read/write address sequence wrong, rd %p wr %p", rd_q, wr_q);
        end
        checks++;
        if (mem[67] !== 24'hA00004 || mem_diffs() != 0) begin
            errors++; $display("FAIL basic_mem: mem[0x43] %h expected a00004, %0d words differ", mem[67], mem_diffs());
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: done %b expected 0 one cycle later", done);
        end
    endtask

    task automatic test_wrap();
        int bc, dc;
        model_copy(24'hFFFFFE, 24'h000020, 3);
        run_copy(24'hFFFFFE, 24'h000020, 24'd3, bc, dc);
        checks++;
        if (seq_errs(rd_q, 24'hFFFFFE, 3) != 0 || rd_q[2] !== 24'h000000) begin
            errors++; $display("FAIL wrap_read: got %p expected fffffe ffffff 000000", rd_q);
        end
        checks++;
        if (seq_errs(wr_q, 24'h000020, 3) != 0 || mem_diffs() != 0 || dc !== 4) begin
            errors++; $display("FAIL wrap_write: wr %p diffs %0d done cycle %0d expected 20..22 0 4", wr_q, mem_diffs(), dc);
        end
    endtask

    task automatic test_len0();
        wen_count = 0;
        src = 24'h000033; dst = 24'h000233; len = 24'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL len0_done: done %b busy %b expected 1 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wen_count !== 0 || mem_diffs() != 0) begin
            errors++; $display("FAIL len0_quiet: done %b busy %b wen %0d expected 0 0 0", done, busy, wen_count);
        end
    endtask

    task automatic test_abort();
        int bc, dc, done_seen;
        wen_count = 0;
        src = 24'h000100; dst = 24'h000300; len = 24'd8; start = 1'b1;
        @(posedge clk); #1;                 // cycle 0
        start = 1'b0;
        @(posedge clk); #1;                 // cycle 1: request that must be ignored
        src = 24'h000000; dst = 24'h000200; len = 24'd5; start = 1'b1;
        @(posedge clk); #1;                 // cycle 2
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;                 // just after abort edge 3
        abort = 1'b0;
        checks++;
        if (mem_wen !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_stop: wen %b busy %b expected 0 0", mem_wen, busy);
        end
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        model_copy(24'h000100, 24'h000300, 2);
        checks++;
        if (done_seen !== 0 || words_done !== 24'd2 || wen_count !== 2) begin
            errors++; $display("FAIL abort_count: done %0d words_done %0d wen %0d expected 0 2 2", done_seen, words_done, wen_count);
        end
        checks++;
        if (mem_diffs() != 0) begin
            errors++; $display("FAIL abort_mem: %0d words differ expected 0", mem_diffs());
        end
        model_copy(24'h000000, 24'h000200, 5);
        run_copy(24'h000000, 24'h000200, 24'd5, bc, dc);
        checks++;
        if (dc !== 6 || words_done !== 24'd5 || mem_diffs() != 0) begin
            errors++; $display("FAIL abort_after: done cycle %0d words_done %0d diffs %0d expected 6 5 0", dc, words_done, mem_diffs());
        end
    endtask

    task automatic test_async_reset();
        int bc, dc;
        src = 24'h000050; dst = 24'h000250; len = 24'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;                                 // cycle 3, word 2 pending
        checks++;
        if (mem_wen !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre: wen %b busy %b expected 1 1", mem_wen, busy);
        end
        #2 rst = 1'b1;
        #1;                                 // still before the negedge
        checks++;
        if (mem_wen !== 1'b0 || busy !== 1'b0 || words_done !== 24'd0) begin
            errors++; $display("FAIL areset_drop: wen %b busy %b words %0d expected 0 0 0", mem_wen, busy, words_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_copy(24'h000050, 24'h000250, 2);
        checks++;
        if (mem_diffs() != 0) begin
            errors++; $display("FAIL areset_mem: %0d words differ expected 0", mem_diffs());
        end
        model_copy(24'h000060, 24'h000260, 7);
        run_copy(24'h000060, 24'h000260, 24'd7, bc, dc);
        checks++;
        if (dc !== 8 || bc !== 8 || mem_diffs() != 0) begin
            errors++; $display("FAIL areset_recover: done %0d busy %0d diffs %0d expected 8 8 0", dc, bc, mem_diffs());
        end
    endtask

    task automatic test_overlap();
        int bc, dc;
        model_copy(24'h000140, 24'h000141, 6);
        run_copy(24'h000140, 24'h000141, 24'd6, bc, dc);
        checks++;
        if (dc !== 7 || mem_diffs() != 0) begin
            errors++; $display("FAIL overlap_move: done %0d diffs %0d expected 7 0", dc, mem_diffs());
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        model_copy(24'h000080, 24'h000280, 7);
        run_copy(24'h000080, 24'h000280, 24'd7, bc, dc);
        checks++;
        if (dc !== 8 || mem_diffs() != 0) begin
            errors++; $display("FAIL b2b_first: done %0d diffs %0d expected 8 0", dc, mem_diffs());
        end
        model_copy(24'h0000C0, 24'h0002C0, 5);
        run_copy(24'h0000C0, 24'h0002C0, 24'd5, bc, dc);   // start raised in the done cycle
        checks++;
        if (dc !== 6 || wen_count !== 5 || seq_errs(wr_q, 24'h0002C0, 5) != 0 || mem_diffs() != 0) begin
            errors++; $display("FAIL b2b_second: done %0d wen %0d diffs %0d expected 6 5 0", dc, wen_count, mem_diffs());
        end
    endtask

    task automatic test_random();
        int bc, dc, n;
        logic [23:0] s, d;
        logic [31:0] hi;
        for (int it = 0; it < 6; it++) begin
            hi = $urandom;
            n  = int'($urandom_range(1, 40));
            s  = {hi[23:10], 10'd0} + 24'($urandom_range(0, 255));
            d  = {hi[13:0], 10'd0} + 24'd512 + 24'($urandom_range(0, 255));
            model_copy(s, d, n);
            run_copy(s, d, 24'(n), bc, dc);
            checks++;
            if (dc !== n + 1 || bc !== n + 1 || words_done !== 24'(n) || wen_count !== n) begin
                errors++; $display("FAIL random_timing[%0d]: done %0d busy %0d words %0d wen %0d expected %0d %0d %0d %0d",
                                   it, dc, bc, words_done, wen_count, n + 1, n + 1, n, n);
            end
            checks++;
            if (seq_errs(rd_q, s, n) != 0 || seq_errs(wr_q, d, n) != 0 || mem_diffs() != 0) begin
                errors++; $display("FAIL random_data[%0d]: src %h dst %h len %0d, %0d words differ", it, s, d, n, mem_diffs());
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; wen_count = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src = 24'd0; dst = 24'd0; len = 24'd0;
        fill_mem();
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_wrap();
        @(posedge clk); #1;
        test_len0();
        test_abort();
        @(posedge clk); #1;
        test_async_reset();
        @(posedge clk); #1;
        test_overlap();
        @(posedge clk); #1;
        test_back_to_back();
        @(posedge clk); #1;
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
